ctrl_pipe_unit: RTL and testbench

- Parametrised successor to the ID-stage main decoder for the 5-stage MIPS pipeline.
- Decodes the opcode and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and applies stall, flush and hold.
- Supplies the stage control signals and destination-register tags that the datapath and forwarding unit consume.

---
 rtl/ctrl_pipe_pkg.sv | 41 ++++
 rtl/ctrl_pipe_unit_decode.sv | 86 ++++++++
 rtl/ctrl_pipe_unit.sv | 113 +++++++++++
 tb/tb_ctrl_pipe_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared opcodes, ALU operation encodings and the control bundle that rides
// through the ID/EX, EX/MEM and MEM/WB registers of the pipeline controller.
package ctrl_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // Destination tags are carried at this width; REG_AW must not exceed it.
  localparam int DST_W = 8;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_SLT   = 3'b110,
    ALU_LUI   = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e            alu_op;
    logic               alu_src;
    logic               reg_dst;
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               illegal;
    logic [DST_W-1:0]   dst;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// Combinational main decoder: opcode and register fields to a control bundle,
// plus the source-usage flags the load-use detector needs.
module ctrl_decode
  import ctrl_pipe_pkg::*;
#(
  parameter bit EXT_OPS = 1'b1,
  parameter int REG_AW  = 5
) (
  input  logic [5:0]        op_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] rd_i,
  output ctrl_bundle_t      ctrl_o,
  output logic              uses_rs_o,
  output logic              uses_rt_o,
  output logic              is_beq_o,
  output logic              is_j_o
);

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; that is what keeps this block free of latches.
  always_comb begin
    ctrl_o    = '0;
    uses_rs_o = 1'b0;
    uses_rt_o = 1'b0;
    is_beq_o  = 1'b0;
    is_j_o    = 1'b0;

    case (op_i)
      OP_RTYPE: begin
        ctrl_o.alu_op    = ALU_FUNCT;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        uses_rs_o        = 1'b1;
        uses_rt_o        = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        uses_rs_o        = 1'b1;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        uses_rs_o         = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        uses_rs_o        = 1'b1;
        uses_rt_o        = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.alu_op = ALU_SUB;
        uses_rs_o     = 1'b1;
        uses_rt_o     = 1'b1;
        is_beq_o      = 1'b1;
      end
      OP_J: is_j_o = 1'b1;
      OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
        if (EXT_OPS) begin
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.reg_write = 1'b1;
          uses_rs_o        = (op_i != OP_LUI);
          case (op_i)
            OP_ANDI: ctrl_o.alu_op = ALU_AND;
            OP_ORI:  ctrl_o.alu_op = ALU_OR;
            OP_SLTI: ctrl_o.alu_op = ALU_SLT;
            default: ctrl_o.alu_op = ALU_LUI;
          endcase
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      default: ctrl_o.illegal = 1'b1;
    endcase

    // A write to $0 is no write at all, so the tag and the enable both drop.
    if (ctrl_o.reg_write) begin
      ctrl_o.dst = ctrl_o.reg_dst ? DST_W'(rd_i) : DST_W'(rt_i);
      if (ctrl_o.dst == '0) ctrl_o.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipeline controller: decodes in ID, carries the control bundle through
// ID/EX, EX/MEM and MEM/WB, and inserts load-use bubbles.
module ctrl_pipe_unit
  import ctrl_pipe_pkg::*;
#(
  parameter bit EXT_OPS      = 1'b1,
  parameter int REG_AW       = 5,
  parameter bit LOAD_USE_DET = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [5:0]        op_i,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              branch_o,
  output logic              jump_o,
  output logic              stall_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic [2:0]        ex_alu_op_o,
  output logic              ex_alu_src_o,
  output logic              ex_reg_dst_o,
  output logic [REG_AW-1:0] ex_dst_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              mem_reg_write_o,
  output logic [REG_AW-1:0] mem_dst_o,
  output logic              wb_reg_write_o,
  output logic              wb_mem_to_reg_o,
  output logic [REG_AW-1:0] wb_dst_o,
  output logic              illegal_o
);

  ctrl_bundle_t id_ctrl;
  logic         uses_rs, uses_rt, is_beq, is_j;
  logic         hazard;
  ctrl_bundle_t idex_d, idex_q, exmem_d, exmem_q, memwb_d, memwb_q;

  ctrl_decode #(
    .EXT_OPS (EXT_OPS),
    .REG_AW  (REG_AW)
  ) u_decode (
    .op_i      (op_i),
    .rt_i      (id_rt_i),
    .rd_i      (id_rd_i),
    .ctrl_o    (id_ctrl),
    .uses_rs_o (uses_rs),
    .uses_rt_o (uses_rt),
    .is_beq_o  (is_beq),
    .is_j_o    (is_j)
  );

  assign hazard = LOAD_USE_DET && valid_i && idex_q.mem_read && (idex_q.dst != '0) &&
                  ((uses_rs && (DST_W'(id_rs_i) == idex_q.dst)) ||
                   (uses_rt && (DST_W'(id_rt_i) == idex_q.dst)));

  // Flush and hold both outrank the stall; under hold the hazard is simply
  // re-evaluated once the pipeline moves again.
  assign stall_o      = hazard && !flush_i && !hold_i;
  assign pc_write_o   = !hold_i && !stall_o;
  assign ifid_write_o = pc_write_o;
  assign branch_o     = valid_i && is_beq && !hazard;
  assign jump_o       = valid_i && is_j && !hazard;

  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    if (!hold_i) begin
      memwb_d = exmem_q;
      exmem_d = idex_q;
      idex_d  = (!valid_i || flush_i || stall_o) ? '0 : id_ctrl;
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value, giving a true shift.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_alu_op_o     = idex_q.alu_op;
  assign ex_alu_src_o    = idex_q.alu_src;
  assign ex_reg_dst_o    = idex_q.reg_dst;
  assign ex_dst_o        = idex_q.dst[REG_AW-1:0];
  assign illegal_o       = idex_q.illegal;
  assign mem_read_o      = exmem_q.mem_read;
  assign mem_write_o     = exmem_q.mem_write;
  assign mem_reg_write_o = exmem_q.reg_write;
  assign mem_dst_o       = exmem_q.dst[REG_AW-1:0];
  assign wb_reg_write_o  = memwb_q.reg_write;
  assign wb_mem_to_reg_o = memwb_q.mem_to_reg;
  assign wb_dst_o        = memwb_q.dst[REG_AW-1:0];

  // Later stages carry the full bundle; the fields they do not expose are
  // trimmed by synthesis.
  logic unused_bits;
  assign unused_bits = ^{exmem_q, memwb_q, idex_q.mem_to_reg, idex_q.mem_write,
                         idex_q.reg_write};

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Drives two controllers (extended ops on and off) with directed and random
// instruction streams and compares every output against a table-driven model.
module tb_ctrl_pipe_unit;

  localparam int AW = 5;

  typedef struct packed {
    logic [2:0]    alu_op;
    logic          alu_src, reg_dst, reg_write, mem_to_reg, mem_read, mem_write, illegal;
    logic [AW-1:0] dst;
  } m_ctrl_t;

  logic          clk = 1'b0;
  logic          rst, valid, flush, hold;
  logic [5:0]    op;
  logic [AW-1:0] rs, rt, rd;

  logic          branch [2], jump [2], stall [2], pc_write [2], ifid_write [2];
  logic [2:0]    ex_alu_op [2];
  logic          ex_alu_src [2], ex_reg_dst [2], illegal [2];
  logic [AW-1:0] ex_dst [2], mem_dst [2], wb_dst [2];
  logic          mem_read [2], mem_write [2], mem_reg_write [2];
  logic          wb_reg_write [2], wb_mem_to_reg [2];

  m_ctrl_t m_ex [2], m_mem [2], m_wb [2];
  int      n_checks = 0;
  int      n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ctrl_pipe_unit #(
      .EXT_OPS      (g == 0),
      .REG_AW       (AW),
      .LOAD_USE_DET (1'b1)
    ) u_dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .op_i            (op),
      .valid_i         (valid),
      .id_rs_i         (rs),
      .id_rt_i         (rt),
      .id_rd_i         (rd),
      .flush_i         (flush),
      .hold_i          (hold),
      .branch_o        (branch[g]),
      .jump_o          (jump[g]),
      .stall_o         (stall[g]),
      .pc_write_o      (pc_write[g]),
      .ifid_write_o    (ifid_write[g]),
      .ex_alu_op_o     (ex_alu_op[g]),
      .ex_alu_src_o    (ex_alu_src[g]),
      .ex_reg_dst_o    (ex_reg_dst[g]),
      .ex_dst_o        (ex_dst[g]),
      .mem_read_o      (mem_read[g]),
      .mem_write_o     (mem_write[g]),
      .mem_reg_write_o (mem_reg_write[g]),
      .mem_dst_o       (mem_dst[g]),
      .wb_reg_write_o  (wb_reg_write[g]),
      .wb_mem_to_reg_o (wb_mem_to_reg[g]),
      .wb_dst_o        (wb_dst[g]),
      .illegal_o       (illegal[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decode straight from the opcode table: aluop/src/regdst/wr/m2r/rd/wr_mem/rs/rt.
  function automatic void m_decode(input bit ext, input logic [5:0] o,
                                   input logic [AW-1:0] f_rt, input logic [AW-1:0] f_rd,
                                   output m_ctrl_t b, output bit urs, output bit urt);
    logic [10:0] row;
    bit          known;
    known = 1'b1;
    row   = '0;
    case (o)
      6'b000000: row = 11'b011_0_1_1_0_0_0_1_1;
      6'b001000: row = 11'b000_1_0_1_0_0_0_1_0;
      6'b100011: row = 11'b000_1_0_1_1_1_0_1_0;
      6'b101011: row = 11'b000_1_0_0_0_0_1_1_1;
      6'b000100: row = 11'b001_0_0_0_0_0_0_1_1;
      6'b000010: row = '0;
      6'b001100: if (ext) row = 11'b100_1_0_1_0_0_0_1_0; else known = 1'b0;
      6'b001101: if (ext) row = 11'b101_1_0_1_0_0_0_1_0; else known = 1'b0;
      6'b001010: if (ext) row = 11'b110_1_0_1_0_0_0_1_0; else known = 1'b0;
      6'b001111: if (ext) row = 11'b111_1_0_1_0_0_0_0_0; else known = 1'b0;
      default:   known = 1'b0;
    endcase
    b            = '0;
    b.alu_op     = row[10:8];
    b.alu_src    = row[7];
    b.reg_dst    = row[6];
    b.reg_write  = row[5];
    b.mem_to_reg = row[4];
    b.mem_read   = row[3];
    b.mem_write  = row[2];
    urs          = row[1];
    urt          = row[0];
    b.illegal    = !known;
    b.dst        = !b.reg_write ? '0 : (b.reg_dst ? f_rd : f_rt);
    if (b.dst == '0) b.reg_write = 1'b0;
  endfunction

  // One clock: present inputs, check every output of both DUTs, advance the model.
  task automatic step(input logic [5:0] s_op, input logic [AW-1:0] s_rs, input logic [AW-1:0] s_rt,
                      input logic [AW-1:0] s_rd, input bit s_valid, input bit s_flush,
                      input bit s_hold, input bit s_rst);
    m_ctrl_t nx_ex [2], nx_mem [2], nx_wb [2];
    @(negedge clk);
    op = s_op; rs = s_rs; rt = s_rt; rd = s_rd;
    valid = s_valid; flush = s_flush; hold = s_hold; rst = s_rst;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_ctrl_t dec;
      bit      urs, urt, hz, stl, pcw, br, jp;
      m_decode(k == 0, s_op, s_rt, s_rd, dec, urs, urt);
      hz  = s_valid && m_ex[k].mem_read && (m_ex[k].dst != 0) &&
            ((urs && s_rs == m_ex[k].dst) || (urt && s_rt == m_ex[k].dst));
      stl = hz && !s_flush && !s_hold;
      pcw = !s_hold && !stl;
      br  = s_valid && (s_op == 6'b000100) && !hz;
      jp  = s_valid && (s_op == 6'b000010) && !hz;
      check($sformatf("ctl%0d", k),
            32'({branch[k], jump[k], stall[k], pc_write[k], ifid_write[k]}),
            32'({br, jp, stl, pcw, pcw}));
      check($sformatf("ex%0d", k),
            32'({ex_alu_op[k], ex_alu_src[k], ex_reg_dst[k], illegal[k], ex_dst[k]}),
            32'({m_ex[k].alu_op, m_ex[k].alu_src, m_ex[k].reg_dst, m_ex[k].illegal, m_ex[k].dst}));
      check($sformatf("mem%0d", k),
            32'({mem_read[k], mem_write[k], mem_reg_write[k], mem_dst[k]}),
            32'({m_mem[k].mem_read, m_mem[k].mem_write, m_mem[k].reg_write, m_mem[k].dst}));
      check($sformatf("wb%0d", k),
            32'({wb_reg_write[k], wb_mem_to_reg[k], wb_dst[k]}),
            32'({m_wb[k].reg_write, m_wb[k].mem_to_reg, m_wb[k].dst}));
      if (s_rst) begin
        nx_ex[k] = '0; nx_mem[k] = '0; nx_wb[k] = '0;
      end else if (s_hold) begin
        nx_ex[k] = m_ex[k]; nx_mem[k] = m_mem[k]; nx_wb[k] = m_wb[k];
      end else begin
        nx_wb[k]  = m_mem[k];
        nx_mem[k] = m_ex[k];
        nx_ex[k]  = (!s_valid || s_flush || stl) ? m_ctrl_t'('0) : dec;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = nx_ex[k]; m_mem[k] = nx_mem[k]; m_wb[k] = nx_wb[k];
    end
  endtask

  task automatic instr(input logic [5:0] s_op, input logic [AW-1:0] s_rs,
                       input logic [AW-1:0] s_rt, input logic [AW-1:0] s_rd);
    step(s_op, s_rs, s_rt, s_rd, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(6'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [5:0] op_pool [12];
    op_pool = '{6'b000000, 6'b001000, 6'b100011, 6'b100011, 6'b101011, 6'b000100,
                6'b000010, 6'b001100, 6'b001101, 6'b001010, 6'b001111, 6'b111111};
    rst = 1'b1; valid = 1'b0; flush = 1'b0; hold = 1'b0;
    op = '0; rs = '0; rt = '0; rd = '0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
    end
    step(6'b100011, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);

    // lw $8 then add reading $8: one bubble, then the add enters EX.
    instr(6'b100011, 5'd1, 5'd8, 5'd0);
    instr(6'b000000, 5'd8, 5'd2, 5'd9);
    #1 check("plan_bubble", 32'({ex_alu_op[0], ex_alu_src[0], ex_reg_dst[0], ex_dst[0]}), 32'd0);
    instr(6'b000000, 5'd8, 5'd2, 5'd9);
    #1 check("plan_add_op", 32'(ex_alu_op[0]), 32'b011);
    check("plan_add_dst", 32'(ex_dst[0]), 32'd9);
    nop(3);

    // lw into $0 followed by a $0 reader.
    instr(6'b100011, 5'd1, 5'd0, 5'd0);
    instr(6'b000000, 5'd0, 5'd0, 5'd3);
    nop(3);

    // addi, sw, beq back to back.
    instr(6'b001000, 5'd1, 5'd4, 5'd0);
    instr(6'b101011, 5'd1, 5'd5, 5'd0);
    instr(6'b000100, 5'd4, 5'd5, 5'd0);
    #1 check("plan_beq_ex", 32'(ex_alu_op[1]), 32'b001);
    nop(3);

    // Hazard coinciding with flush.
    instr(6'b100011, 5'd1, 5'd8, 5'd0);
    step(6'b000000, 5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    nop(2);

    // Three-cycle hold in mid-stream, including one with a pending hazard.
    instr(6'b100011, 5'd1, 5'd7, 5'd0);
    for (int i = 0; i < 3; i++) step(6'b000000, 5'd7, 5'd3, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    instr(6'b000000, 5'd7, 5'd3, 5'd6);
    instr(6'b000000, 5'd7, 5'd3, 5'd6);
    nop(3);

    // ori with and without extended ops, then an opcode illegal in both.
    instr(6'b001101, 5'd1, 5'd6, 5'd0);
    #1 check("plan_ori_ext", 32'(ex_alu_op[0]), 32'b101);
    check("plan_ori_base", 32'({illegal[1], ex_alu_op[1], ex_alu_src[1]}), 32'b1_000_0);
    nop(1);
    instr(6'b111111, 5'd1, 5'd2, 5'd3);
    #1 check("plan_ff_illegal", 32'({illegal[0], illegal[1]}), 32'b11);
    nop(2);

    // Reset in the middle of a stall.
    instr(6'b100011, 5'd1, 5'd8, 5'd0);
    step(6'b000000, 5'd8, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    nop(2);

    for (int i = 0; i < 3000; i++) begin
      step(op_pool[$urandom_range(0, 11)] ^ (($urandom_range(0, 15) == 0) ? 6'($urandom) : 6'd0),
           AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 10, $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
